// File: rtl/ceu_wr_arb.sv
// ceu_wr_arb: packet-level 2:1 arbiter that merges two CEU outbox write-request
// streams into one DMA write-request stream through a single register stage.
// A packet, once started on a port, owns the output until its last beat.
// Build option: define CEU_WR_ARB_CNT_EN to add cnt_bus, which carries the
// per-port packet counts {port1[31:0], port0[31:0]}.
//
// Handshake: on every port a beat transfers at a rising clk edge where valid
// and ready are both 1. A source may lower valid between beats of a packet.
// The source-side readies look at the source valids only while the arbiter is
// idle. The output side is a plain register stage that loads when it is empty
// or being drained.
module ceu_wr_arb #(
   parameter int DMA_HEAD_WIDTH = 128,
   parameter int DATA_WIDTH     = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s0_wr_req_valid,
   input  logic                      s0_wr_req_last,
   input  logic [DATA_WIDTH-1:0]     s0_wr_req_data,
   input  logic [DMA_HEAD_WIDTH-1:0] s0_wr_req_head,
   output logic                      s0_wr_req_ready,
   input  logic                      s1_wr_req_valid,
   input  logic                      s1_wr_req_last,
   input  logic [DATA_WIDTH-1:0]     s1_wr_req_data,
   input  logic [DMA_HEAD_WIDTH-1:0] s1_wr_req_head,
   output logic                      s1_wr_req_ready,
   output logic                      m_wr_req_valid,
   output logic                      m_wr_req_last,
   output logic [DATA_WIDTH-1:0]     m_wr_req_data,
   output logic [DMA_HEAD_WIDTH-1:0] m_wr_req_head,
   input  logic                      m_wr_req_ready,
   output logic [2:0]                state_dbg
`ifdef CEU_WR_ARB_CNT_EN
   ,
   output logic [63:0]               cnt_bus
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      LOCK0 = 3'b010,
      LOCK1 = 3'b100
   } state_t;

   state_t state;
   logic   rr_ptr;     // 0: port 0 wins a tie in IDLE, 1: port 1 wins
   logic   can_load;
   logic   gnt0;
   logic   gnt1;
   logic   acc0;
   logic   acc1;

   // The output register may take a new beat when it is empty or being drained.
   assign can_load = ~m_wr_req_valid | m_wr_req_ready;

   // Grant: IDLE picks among valid ports (round robin on a tie), LOCKn keeps port n.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         IDLE: begin
            gnt0 = s0_wr_req_valid & (~s1_wr_req_valid | ~rr_ptr);
            gnt1 = s1_wr_req_valid & (~s0_wr_req_valid |  rr_ptr);
         end
         LOCK0:   gnt0 = 1'b1;
         LOCK1:   gnt1 = 1'b1;
         default: begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      endcase
   end

   // Readies are forced low while reset is held so no beat is taken then.
   assign s0_wr_req_ready = rst_n & gnt0 & can_load;
   assign s1_wr_req_ready = rst_n & gnt1 & can_load;
   assign acc0            = s0_wr_req_valid & s0_wr_req_ready;
   assign acc1            = s1_wr_req_valid & s1_wr_req_ready;
   assign state_dbg       = state;

   // Arbitration FSM: lock onto a multi-beat packet, release and pass priority on its last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc0) begin
                  if (s0_wr_req_last) rr_ptr <= 1'b1;
                  else                state  <= LOCK0;
               end else if (acc1) begin
                  if (s1_wr_req_last) rr_ptr <= 1'b0;
                  else                state  <= LOCK1;
               end
            end
            LOCK0: begin
               if (acc0 && s0_wr_req_last) begin
                  state  <= IDLE;
                  rr_ptr <= 1'b1;
               end
            end
            LOCK1: begin
               if (acc1 && s1_wr_req_last) begin
                  state  <= IDLE;
                  rr_ptr <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output stage: capture the accepted beat, hold it under backpressure, clear valid once drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wr_req_valid <= 1'b0;
         m_wr_req_last  <= 1'b0;
         m_wr_req_data  <= '0;
         m_wr_req_head  <= '0;
      end else if (acc0) begin
         m_wr_req_valid <= 1'b1;
         m_wr_req_last  <= s0_wr_req_last;
         m_wr_req_data  <= s0_wr_req_data;
         m_wr_req_head  <= s0_wr_req_head;
      end else if (acc1) begin
         m_wr_req_valid <= 1'b1;
         m_wr_req_last  <= s1_wr_req_last;
         m_wr_req_data  <= s1_wr_req_data;
         m_wr_req_head  <= s1_wr_req_head;
      end else if (m_wr_req_ready) begin
         m_wr_req_valid <= 1'b0;
      end
   end

`ifdef CEU_WR_ARB_CNT_EN
   logic [31:0] pkt_cnt0;
   logic [31:0] pkt_cnt1;

   // Count completed packets per port; the counters wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (acc0 && s0_wr_req_last) pkt_cnt0 <= pkt_cnt0 + 32'd1;
         if (acc1 && s1_wr_req_last) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
   end

   assign cnt_bus = {pkt_cnt1, pkt_cnt0};
`endif

endmodule

// File: tb/tb_ceu_wr_arb.sv
// tb_ceu_wr_arb: bench for ceu_wr_arb. Sources are fed from per-port beat queues,
// and a packet-level reference model predicts the readies and the output register.
// Define CEU_WR_ARB_CNT_EN to also cover the packet counters.
module tb_ceu_wr_arb;

   localparam int DW = 256;
   localparam int HW = 128;
   localparam int BW = 1 + HW + DW;

   typedef struct packed {
      logic [3:0]    gap;
      logic [BW-1:0] b;     // {last, head, data}
   } src_t;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          s0_wr_req_valid, s0_wr_req_last, s0_wr_req_ready;
   logic [DW-1:0] s0_wr_req_data;
   logic [HW-1:0] s0_wr_req_head;
   logic          s1_wr_req_valid, s1_wr_req_last, s1_wr_req_ready;
   logic [DW-1:0] s1_wr_req_data;
   logic [HW-1:0] s1_wr_req_head;
   logic          m_wr_req_valid, m_wr_req_last, m_wr_req_ready;
   logic [DW-1:0] m_wr_req_data;
   logic [HW-1:0] m_wr_req_head;
   logic [2:0]    state_dbg;
`ifdef CEU_WR_ARB_CNT_EN
   logic [63:0]   cnt_bus;
`endif

   ceu_wr_arb #(.DMA_HEAD_WIDTH(HW), .DATA_WIDTH(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s0_wr_req_valid (s0_wr_req_valid),
      .s0_wr_req_last  (s0_wr_req_last),
      .s0_wr_req_data  (s0_wr_req_data),
      .s0_wr_req_head  (s0_wr_req_head),
      .s0_wr_req_ready (s0_wr_req_ready),
      .s1_wr_req_valid (s1_wr_req_valid),
      .s1_wr_req_last  (s1_wr_req_last),
      .s1_wr_req_data  (s1_wr_req_data),
      .s1_wr_req_head  (s1_wr_req_head),
      .s1_wr_req_ready (s1_wr_req_ready),
      .m_wr_req_valid  (m_wr_req_valid),
      .m_wr_req_last   (m_wr_req_last),
      .m_wr_req_data   (m_wr_req_data),
      .m_wr_req_head   (m_wr_req_head),
      .m_wr_req_ready  (m_wr_req_ready),
      .state_dbg       (state_dbg)
`ifdef CEU_WR_ARB_CNT_EN
      ,
      .cnt_bus         (cnt_bus)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- driver ----------------
   src_t src0_q[$];
   src_t src1_q[$];
   int   wait0  = 0;
   int   wait1  = 0;
   int   vprob  = 100;
   int   mprob  = 100;
   int   mforce = -1;
   logic acc0_q = 1'b0;
   logic acc1_q = 1'b0;

   always @(posedge clk) begin
      acc0_q <= s0_wr_req_valid & s0_wr_req_ready;
      acc1_q <= s1_wr_req_valid & s1_wr_req_ready;
   end

   task automatic push(input int p, input int gap, input logic last,
                       input logic [HW-1:0] head, input logic [DW-1:0] data);
      src_t s;
      s.gap = 4'(gap);
      s.b   = {last, head, data};
      if (p == 0) src0_q.push_back(s);
      else        src1_q.push_back(s);
   endtask

   initial begin
      src_t sdrop;
      s0_wr_req_valid = 1'b0; s0_wr_req_last = 1'b0; s0_wr_req_data = '0; s0_wr_req_head = '0;
      s1_wr_req_valid = 1'b0; s1_wr_req_last = 1'b0; s1_wr_req_data = '0; s1_wr_req_head = '0;
      m_wr_req_ready  = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (acc0_q && src0_q.size() > 0) begin
            sdrop = src0_q.pop_front();
            if (src0_q.size() > 0) wait0 = int'(src0_q[0].gap);
         end
         if (wait0 > 0) begin
            s0_wr_req_valid = 1'b0;
            wait0--;
         end else if (src0_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
            s0_wr_req_valid = 1'b1;
            {s0_wr_req_last, s0_wr_req_head, s0_wr_req_data} = src0_q[0].b;
         end else begin
            s0_wr_req_valid = 1'b0;
         end
         if (acc1_q && src1_q.size() > 0) begin
            sdrop = src1_q.pop_front();
            if (src1_q.size() > 0) wait1 = int'(src1_q[0].gap);
         end
         if (wait1 > 0) begin
            s1_wr_req_valid = 1'b0;
            wait1--;
         end else if (src1_q.size() > 0 && int'($urandom_range(99)) < vprob) begin
            s1_wr_req_valid = 1'b1;
            {s1_wr_req_last, s1_wr_req_head, s1_wr_req_data} = src1_q[0].b;
         end else begin
            s1_wr_req_valid = 1'b0;
         end
         if (mforce >= 0) m_wr_req_ready = mforce[0];
         else             m_wr_req_ready = int'($urandom_range(99)) < mprob;
      end
   end

   // ---------------- reference model + scoreboard ----------------
   logic [BW-1:0] exp_q[$];
   logic [15:0]   log_data[$];
   logic          log_last[$];
   logic [HW-1:0] log_head[$];
   int            cur_owner = -1;   // port whose packet is in progress, -1 if none
   int            last_port = 1;    // port that finished the most recent packet
   logic          e_v = 1'b0;
   logic [BW-1:0] e_b = '0;
   int            s1_rdy_cnt = 0;
   int            stall_cnt  = 0;
   int unsigned   mc0 = 0;
   int unsigned   mc1 = 0;

   initial begin
      int            owner;
      logic          can, er0, er1, a0, a1;
      logic [BW-1:0] t;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cur_owner = -1; last_port = 1; e_v = 1'b0; e_b = '0;
            mc0 = 0; mc1 = 0;
            exp_q.delete();
            chk("rst_m_valid", 512'(m_wr_req_valid), 512'(0));
            chk("rst_m_last",  512'(m_wr_req_last),  512'(0));
            chk("rst_m_data",  512'(m_wr_req_data),  512'(0));
            chk("rst_m_head",  512'(m_wr_req_head),  512'(0));
            chk("rst_s0_ready", 512'(s0_wr_req_ready), 512'(0));
            chk("rst_s1_ready", 512'(s1_wr_req_ready), 512'(0));
         end else begin
            can = !e_v || m_wr_req_ready;
            if (cur_owner >= 0)                         owner = cur_owner;
            else if (s0_wr_req_valid && s1_wr_req_valid) owner = (last_port == 0) ? 1 : 0;
            else if (s0_wr_req_valid)                    owner = 0;
            else if (s1_wr_req_valid)                    owner = 1;
            else                                         owner = -1;
            er0 = (owner == 0) && can;
            er1 = (owner == 1) && can;
            chk("s0_ready", 512'(s0_wr_req_ready), 512'(er0));
            chk("s1_ready", 512'(s1_wr_req_ready), 512'(er1));
            chk("state_onehot", 512'($onehot(state_dbg)), 512'(1));
            chk("m_valid", 512'(m_wr_req_valid), 512'(e_v));
            if (e_v) chk("m_beat", 512'({m_wr_req_last, m_wr_req_head, m_wr_req_data}), 512'(e_b));
`ifdef CEU_WR_ARB_CNT_EN
            chk("cnt_bus", 512'(cnt_bus), 512'({mc1, mc0}));
`endif
            if (s1_wr_req_ready) s1_rdy_cnt++;
            if (m_wr_req_valid && !m_wr_req_ready) stall_cnt++;
            if (m_wr_req_valid && m_wr_req_ready) begin
               log_data.push_back(m_wr_req_data[15:0]);
               log_last.push_back(m_wr_req_last);
               log_head.push_back(m_wr_req_head);
               chk("sb_nonempty", 512'(exp_q.size() != 0), 512'(1));
               if (exp_q.size() != 0) begin
                  t = exp_q.pop_front();
                  chk("sb_beat", 512'({m_wr_req_last, m_wr_req_head, m_wr_req_data}), 512'(t));
               end
            end
            // advance the model to the state after the coming rising edge
            a0 = s0_wr_req_valid && er0;
            a1 = s1_wr_req_valid && er1;
            if (a0 || a1) begin
               e_v = 1'b1;
               e_b = a0 ? {s0_wr_req_last, s0_wr_req_head, s0_wr_req_data}
                        : {s1_wr_req_last, s1_wr_req_head, s1_wr_req_data};
               exp_q.push_back(e_b);
               if (e_b[BW-1]) begin
                  cur_owner = -1;
                  last_port = a0 ? 0 : 1;
                  if (a0) mc0++; else mc1++;
               end else begin
                  cur_owner = a0 ? 0 : 1;
               end
            end else if (m_wr_req_ready) begin
               e_v = 1'b0;
            end
         end
      end
   end

   // ---------------- test sequences ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      src0_q.delete(); src1_q.delete();
      wait0 = 0; wait1 = 0;
      log_data.delete(); log_last.delete(); log_head.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic run_round(input int np, input int vp, input int mp);
      int nbeats = 0;
      int n = 0;
      logic [DW-1:0] d;
      logic [HW-1:0] h;
      int p, len;
      do_reset();
      vprob = vp; mprob = mp; mforce = -1;
      for (int i = 0; i < np; i++) begin
         p   = int'($urandom_range(1));
         len = int'($urandom_range(1, 4));
         h   = {$urandom, $urandom, $urandom, $urandom};
         for (int b = 0; b < len; b++) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            d[15:0] = {4'(p), 8'(i), 4'(b)};
            push(p, int'($urandom_range(2)), b == len - 1, h, d);
            nbeats++;
         end
      end
      while ((src0_q.size() != 0 || src1_q.size() != 0) && n < 20000) begin
         tick();
         n++;
      end
      chk("drain_timeout", 512'(src0_q.size() + src1_q.size()), 512'(0));
      mprob = 100;
      repeat (6) tick();
      chk("sb_left", 512'(exp_q.size()), 512'(0));
      chk("beat_count", 512'(log_data.size()), 512'(nbeats));
      chk("m_idle", 512'(m_wr_req_valid), 512'(0));
      vprob = 100;
   endtask

   initial begin
      logic [HW-1:0] h1;
      h1 = 128'h0000_1111_0000_0000_0000_2000_0000_0040;
      repeat (3) tick();
      chk("por_m_valid", 512'(m_wr_req_valid), 512'(0));
      rst_n = 1'b1;
      tick();

      // two-beat packet on port 0, port 1 idle
      do_reset();
      push(0, 0, 1'b0, h1, 256'hA1);
      push(0, 0, 1'b1, h1, 256'hA2);
      repeat (8) tick();
      chk("p2_count", 512'(log_data.size()), 512'(2));
      chk("p2_d0", 512'(log_data[0]), 512'(16'h00A1));
      chk("p2_d1", 512'(log_data[1]), 512'(16'h00A2));
      chk("p2_l0", 512'(log_last[0]), 512'(0));
      chk("p2_l1", 512'(log_last[1]), 512'(1));
      chk("p2_h0", 512'(log_head[0]), 512'(h1));
      chk("p2_h1", 512'(log_head[1]), 512'(h1));

      // simultaneous single-beat packets alternate s0,s1,s0,s1
      do_reset();
      push(0, 0, 1'b1, h1, 256'hA000);
      push(0, 0, 1'b1, h1, 256'hA001);
      push(1, 0, 1'b1, h1, 256'hB000);
      push(1, 0, 1'b1, h1, 256'hB001);
      repeat (8) tick();
      chk("rr_count", 512'(log_data.size()), 512'(4));
      chk("rr_0", 512'(log_data[0]), 512'(16'hA000));
      chk("rr_1", 512'(log_data[1]), 512'(16'hB000));
      chk("rr_2", 512'(log_data[2]), 512'(16'hA001));
      chk("rr_3", 512'(log_data[3]), 512'(16'hB001));

      // port 0 locked with a 3-cycle valid gap; port 1 waits for s0 last
      do_reset();
      push(0, 0, 1'b0, h1, 256'hC1);
      push(0, 3, 1'b1, h1, 256'hC2);
      push(1, 0, 1'b1, h1, 256'hD1);
      s1_rdy_cnt = 0;
      repeat (14) tick();
      chk("lock_s1_ready_cycles", 512'(s1_rdy_cnt), 512'(1));
      chk("lock_count", 512'(log_data.size()), 512'(3));
      chk("lock_0", 512'(log_data[0]), 512'(16'h00C1));
      chk("lock_1", 512'(log_data[1]), 512'(16'h00C2));
      chk("lock_2", 512'(log_data[2]), 512'(16'h00D1));

      // output backpressure for 5 cycles
      do_reset();
      push(0, 0, 1'b1, h1, 256'hE0);
      push(0, 0, 1'b1, h1, 256'hE1);
      push(0, 0, 1'b1, h1, 256'hE2);
      stall_cnt = 0;
      tick();
      mforce = 0;
      repeat (5) tick();
      mforce = 1;
      repeat (6) tick();
      mforce = -1;
      chk("bp_stall_cycles", 512'(stall_cnt), 512'(5));
      chk("bp_count", 512'(log_data.size()), 512'(3));
      chk("bp_0", 512'(log_data[0]), 512'(16'h00E0));
      chk("bp_1", 512'(log_data[1]), 512'(16'h00E1));
      chk("bp_2", 512'(log_data[2]), 512'(16'h00E2));

      // reset in the middle of a port 1 packet
      do_reset();
      push(1, 0, 1'b0, h1, 256'hF1);
      push(1, 5, 1'b1, h1, 256'hF2);
      tick();
      tick();
      chk("mid_lock1", 512'(state_dbg), 512'(3'b100));
      chk("mid_valid", 512'(m_wr_req_valid), 512'(1));
      rst_n = 1'b0;
      src0_q.delete(); src1_q.delete(); wait0 = 0; wait1 = 0;
      log_data.delete(); log_last.delete(); log_head.delete();
      #1;
      chk("mid_rst_valid", 512'(m_wr_req_valid), 512'(0));
      chk("mid_rst_data",  512'(m_wr_req_data),  512'(0));
      chk("mid_rst_head",  512'(m_wr_req_head),  512'(0));
      chk("mid_rst_state", 512'(state_dbg), 512'(3'b001));
      tick();
      tick();
      push(0, 0, 1'b1, h1, 256'h0C0);
      push(1, 0, 1'b1, h1, 256'h0D0);
      rst_n = 1'b1;
      repeat (6) tick();
      chk("post_rst_count", 512'(log_data.size()), 512'(2));
      chk("post_rst_0", 512'(log_data[0]), 512'(16'h00C0));
      chk("post_rst_1", 512'(log_data[1]), 512'(16'h00D0));

`ifdef CEU_WR_ARB_CNT_EN
      do_reset();
      for (int i = 0; i < 3; i++) push(0, 0, 1'b1, h1, 256'(i));
      for (int i = 0; i < 2; i++) push(1, 0, 1'b1, h1, 256'(i));
      repeat (10) tick();
      chk("cnt_literal", 512'(cnt_bus), 512'({32'd2, 32'd3}));
`endif

      // randomized rounds: mixed pressure, full throughput, heavy backpressure
      run_round(300, 70, 70);
      run_round(300, 100, 100);
      run_round(200, 50, 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
